clint_timer_responder: RTL
==========================

// Module: clint_timer_responder
// PURPOSE
//  Memory-mapped core-local interrupt source (CLINT-style) on the pipeline's data-memory port.
//  It answers dmem read/write requests for its register window.
//  It drives the core's timer_irq from a 64-bit mtime/mtimecmp compare and sw_irq from MSIP.
//  Sits beside data memory; an address decoder routes dmem accesses to it.
// PARAMETERS
//  XLEN      32            bus data/address width
//  BASE_ADDR 32'h0200_0000 window base; window size is 64 KiB (addr[15:0] = offset)
//  PRESCALE  1             clk cycles per mtime increment (>=1)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  bus_addr   in   XLEN  byte address; addr[1:0] ignored (word access only)
//  bus_read   in   1     read request (level)
//  bus_write  in   1     write request (level)
//  bus_wdata  in   XLEN  write data
//  bus_rdata  out  XLEN  read data, valid while bus_ready=1
//  bus_ready  out  1     one-cycle completion pulse
//  timer_irq  out  1     machine timer interrupt (level)
//  sw_irq     out  1     machine software interrupt (level)
//  mtime_out  out  64    current mtime, for debug/trace
// BEHAVIOUR
//  Reset values: bus_rdata=0, bus_ready=0, timer_irq=0, sw_irq=0.
//  Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescale counter=0.
//  Reset asserted mid-transaction aborts it; no ready pulse is issued for it.
//  Register map (offset from BASE_ADDR):
//   0x0000 MSIP (bit0 R/W, bits[31:1] read 0)
//   0x4000 mtimecmp[31:0]    0x4004 mtimecmp[63:32]
//   0xBFF8 mtime[31:0]       0xBFFC mtime[63:32]
//  sel = (bus_read|bus_write) && bus_addr[XLEN-1:16]==BASE_ADDR[XLEN-1:16].
//  Handshake FSM, two states:
//   IDLE: if sel, perform access at this edge, set bus_ready<=1, go to RESP.
//   IDLE: if not sel, bus_ready stays 0.
//   RESP: bus_ready<=0, go to IDLE; no access is accepted in RESP.
//   The initiator drops its request in the cycle it sees ready.
//   A request still held in RESP is a new access, accepted on the next IDLE edge.
//   Latency: request sampled at edge N -> bus_ready=1 and bus_rdata valid after edge N, for exactly one cycle.
//   bus_read and bus_write both high: treated as a write; bus_rdata=0.
//   bus_rdata holds its last value when bus_ready=0.
//  Unmapped offsets inside the window: read returns 0, write ignored, ready still pulses.
//  Addresses outside the window: no response, no state change.
//  mtime counting:
//   The prescale counter counts 0..PRESCALE-1; mtime+=1 (64-bit, carry lo->hi) on wrap.
//   mtime wraps 2^64-1 -> 0.
//   A bus write to mtime lo or hi wins over an increment in the same cycle.
//   The other half keeps its value; no carry is applied that cycle.
//   A read returns mtime as registered before the sampling edge.
//  Interrupt outputs:
//   timer_irq <= (mtime >= mtimecmp), unsigned 64-bit, registered: one cycle after the condition.
//   After a mtimecmp/mtime write, timer_irq updates on the edge following the write edge.
//   sw_irq <= msip[0], registered (visible the cycle after the write's ready).
// TESTING
//  1 Reset: hold rst_n=0 -> outputs 0, read 0xBFF8 returns 0, read 0x4000 returns 32'hFFFFFFFF, timer_irq=0.
//  2 PRESCALE=4: run 40 cycles after reset -> mtime_out=10 (+/-1 for alignment), mtime strictly monotonic.
//  3 Write mtimecmp hi=0, lo=20 -> timer_irq rises one cycle after mtime reaches 20.
//  3 (cont.) Write mtimecmp lo=0xFFFFFFFF, hi=0xFFFFFFFF -> timer_irq falls within 2 cycles.
//  4 Write MSIP=1 -> sw_irq=1 one cycle after ready; write 0 -> sw_irq=0; read MSIP returns 1/0.
//  5 Write mtime lo=0xFFFFFFFE, hi=0, PRESCALE=1 -> after 2 increments hi=1, lo=0.
//  5 (cont.) Write hi in a tick cycle -> written value kept.
//  6 Read offset 0x0100 -> ready pulse, rdata=0; access at BASE+0x10000 -> no ready.
//  6 (cont.) Held request -> one ready every 2 cycles; rst_n pulse during RESP -> ready=0 immediately.

Source files
------------

// File: rtl/clint_timer_responder.sv
// CLINT-style timer/software interrupt source on the data-memory port.
// Holds the 64-bit mtime/mtimecmp pair and MSIP, and answers word accesses with a one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for a selected request; the access is performed on the accepting edge
// RESP  | ready pulse is being driven; requests are ignored for this cycle
module clint_timer_responder #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   BASE_ADDR = 32'h0200_0000,
    parameter int unsigned       PRESCALE  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] bus_addr,
    input  logic            bus_read,
    input  logic            bus_write,
    input  logic [XLEN-1:0] bus_wdata,
    output logic [XLEN-1:0] bus_rdata,
    output logic            bus_ready,
    output logic            timer_irq,
    output logic            sw_irq,
    output logic [63:0]     mtime_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    localparam logic [15:0] OFF_MSIP      = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP0 = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP1 = 16'h4004;
    localparam logic [15:0] OFF_MTIME0    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME1    = 16'hBFFC;

    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [0:0]    state;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [PW-1:0] presc_cnt;
    logic          tick;
    logic          sel;
    logic          accept;
    logic          do_write;
    logic [15:0]   offset;
    logic [31:0]   rd_word;
    logic          unused_ok;

    // Byte lanes are not decoded; every access is a full word.
    assign unused_ok = &{1'b0, bus_addr[1:0]};

    assign offset    = {bus_addr[15:2], 2'b00};
    assign sel       = (bus_read | bus_write) && (bus_addr[XLEN-1:16] == BASE_ADDR[XLEN-1:16]);
    assign accept    = (state == IDLE) && sel;
    assign do_write  = accept && bus_write;
    assign tick      = (presc_cnt == PRESC_LAST);
    assign mtime_out = mtime;

    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_MSIP:      rd_word = {31'd0, msip};
            OFF_MTIMECMP0: rd_word = mtimecmp[31:0];
            OFF_MTIMECMP1: rd_word = mtimecmp[63:32];
            OFF_MTIME0:    rd_word = mtime[31:0];
            OFF_MTIME1:    rd_word = mtime[63:32];
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel) begin
                        state     <= RESP;
                        bus_ready <= 1'b1;
                        bus_rdata <= bus_write ? '0 : XLEN'(rd_word);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    bus_ready <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bus_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // A bus write to either half replaces that half and suppresses the tick for this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else if (do_write && offset == OFF_MTIME0) begin
            mtime <= {mtime[63:32], bus_wdata[31:0]};
        end else if (do_write && offset == OFF_MTIME1) begin
            mtime <= {bus_wdata[31:0], mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else if (do_write) begin
            case (offset)
                OFF_MSIP:      msip            <= bus_wdata[0];
                OFF_MTIMECMP0: mtimecmp[31:0]  <= bus_wdata[31:0];
                OFF_MTIMECMP1: mtimecmp[63:32] <= bus_wdata[31:0];
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_irq <= 1'b0;
            sw_irq    <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
            sw_irq    <= msip;
        end
    end

endmodule
